// File: rtl/fm_stream_pkg.sv
// Shared stream definitions for the byte-serialising blocks.
//   BYTE_WIDTH : width of one output byte
//   state_t    : IDLE (no word held) / SHIFT (word held, bytes being emitted)
package fm_stream_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/byte_mux_hold_reg.sv
// Pending-word holding register for byte_mux.
// Exists only when BYTE_MUX_DOUBLE_BUFFER_EN is defined.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : capture load_data and set full
//   clear      : drop held word (wins over load)
//   load_data  : word to capture
//   full       : a word is held
//   data       : held word
`ifdef BYTE_MUX_DOUBLE_BUFFER_EN
module byte_mux_hold_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_data,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            data <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
        end
    end

endmodule
`endif

// File: rtl/byte_mux.sv
// byte_mux: serialises blockSize-byte words into a byte stream,
// little-endian (byte 0 = inData[7:0] first).
// Optional macro BYTE_MUX_DOUBLE_BUFFER_EN adds a pending-word register so
// the next word follows the last byte without an idle cycle.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   inValid    : upstream word present on inData
//   inReady    : block can accept a word (from registered state only)
//   inData     : input word
//   outEnable  : downstream consumes current byte
//   outValid   : outData holds a valid byte
//   outData    : current byte, registered
module byte_mux
    import fm_stream_pkg::*;
#(
    parameter int blockSize = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           inValid,
    output logic                           inReady,
    input  logic [BYTE_WIDTH*blockSize-1:0] inData,
    input  logic                           outEnable,
    output logic                           outValid,
    output logic [BYTE_WIDTH-1:0]          outData
);

    localparam int IDX_W = (blockSize > 1) ? $clog2(blockSize) : 1;

    typedef logic [blockSize-1:0][BYTE_WIDTH-1:0] word_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    word_t                 word;
    word_t                 in_word;
    word_t                 next_word;
    logic [BYTE_WIDTH-1:0] out_data;
    logic                  xfer;
    logic                  consume;
    logic                  last;
    logic                  load_active;

    assign in_word  = inData;
    assign outValid = (state == SHIFT);
    assign outData  = out_data;
    assign xfer     = inValid && inReady;
    assign consume  = outValid && outEnable;
    assign last     = (idx == IDX_W'(blockSize - 1));
    assign idx_nxt  = idx + IDX_W'(1);

`ifdef BYTE_MUX_DOUBLE_BUFFER_EN
    logic  pend_full;
    word_t pend_data;
    logic  pend_load;
    logic  pend_clear;

    // reset term keeps inReady low for the whole reset cycle
    assign inReady    = !reset && !pend_full;
    // a word arriving while shifting is parked, unless the last byte leaves
    // on the same edge, in which case it goes straight to the active word
    assign pend_load  = xfer && (state == SHIFT) && !(consume && last);
    assign pend_clear = consume && last && pend_full;
    assign load_active = (xfer && (state == IDLE))
                       || (consume && last && (pend_full || xfer));
    // pending is never full in IDLE, so this also covers IDLE-time loads
    assign next_word  = pend_full ? pend_data : in_word;

    byte_mux_hold_reg #(
        .WIDTH(BYTE_WIDTH*blockSize)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .load     (pend_load),
        .clear    (pend_clear),
        .load_data(in_word),
        .full     (pend_full),
        .data     (pend_data)
    );
`else
    assign inReady     = !reset && (state == IDLE);
    assign load_active = xfer;
    assign next_word   = in_word;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            word     <= '0;
            out_data <= '0;
        end else if (load_active) begin
            state    <= SHIFT;
            idx      <= '0;
            word     <= next_word;
            out_data <= next_word[0];
        end else if (consume) begin
            if (!last) begin
                idx      <= idx_nxt;
                out_data <= word[idx_nxt];
            end else begin
                state    <= IDLE;
                idx      <= '0;
                out_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_byte_mux.sv
// Self-checking bench for byte_mux: three instances (blockSize 1, 2, 4),
// directed scenarios followed by a randomized run on the 4-byte instance
// checked against a byte-queue reference model.
module tb_byte_mux;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       iv1, ir1, oe1, ov1;
    logic [7:0] id1, od1;
    logic        iv2, ir2, oe2, ov2;
    logic [15:0] id2;
    logic [7:0]  od2;
    logic        iv4, ir4, oe4, ov4;
    logic [31:0] id4;
    logic [7:0]  od4;

    byte_mux #(.blockSize(1)) u1 (.clk(clk), .reset(reset), .inValid(iv1), .inReady(ir1),
        .inData(id1), .outEnable(oe1), .outValid(ov1), .outData(od1));
    byte_mux #(.blockSize(2)) u2 (.clk(clk), .reset(reset), .inValid(iv2), .inReady(ir2),
        .inData(id2), .outEnable(oe2), .outValid(ov2), .outData(od2));
    byte_mux #(.blockSize(4)) u4 (.clk(clk), .reset(reset), .inValid(iv4), .inReady(ir4),
        .inData(id4), .outEnable(oe4), .outValid(ov4), .outData(od4));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] words2 [2];
    logic [8:0]  exp31  [6];
    logic [7:0]  words1 [3];
    logic [7:0]  got1   [$];
    logic [7:0]  q      [$];
    logic [31:0] w4;
    int          wi;
    logic        rdy, acc, con, pv;
    logic [7:0]  pd, expb;
    int          eidx;

    initial begin
        reset = 1'b1;
        iv1 = 0; id1 = '0; oe1 = 0;
        iv2 = 0; id2 = '0; oe2 = 0;
        iv4 = 0; id4 = '0; oe4 = 0;

        // ---- reset state ----
        tick; tick;
        chk("rst_inReady", ir2, 0);
        chk("rst_outValid", ov2, 0);
        chk("rst_outData", od2, 0);
        reset = 1'b0;
        tick;
        chk("post_rst_inReady", ir2, 1);
        chk("post_rst_outValid", ov2, 0);

        // ---- outEnable while idle is ignored ----
        oe2 = 1;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("idle_outValid", ov2, 0);
            chk("idle_inReady", ir2, 1);
        end

        // ---- 0xBEEF, outEnable held ----
        iv2 = 1; id2 = 16'hBEEF;
        tick;
        iv2 = 0;
        chk("beef_v0", ov2, 1);
        chk("beef_b0", od2, 8'hEF);
        tick;
        chk("beef_v1", ov2, 1);
        chk("beef_b1", od2, 8'hBE);
        tick;
        chk("beef_end_v", ov2, 0);
        chk("beef_end_d", od2, 0);

        // ---- back-to-back words ----
        words2[0] = 16'h1111; words2[1] = 16'h2222;
`ifdef BYTE_MUX_DOUBLE_BUFFER_EN
        exp31 = '{9'h111, 9'h111, 9'h122, 9'h122, 9'h000, 9'h000};
`else
        exp31 = '{9'h111, 9'h111, 9'h000, 9'h122, 9'h122, 9'h000};
`endif
        wi = 0; oe2 = 1;
        for (int c = 0; c < 6; c++) begin
            iv2 = (wi < 2);
            id2 = (wi < 2) ? words2[wi] : 16'h0;
            rdy = ir2;
            tick;
            if (iv2 && rdy) wi++;
            chk("b2b_seq", {ov2, od2}, exp31[c]);
        end
        iv2 = 0;

        // ---- blockSize=4, toggling outEnable ----
        w4 = 32'h12345678;
        iv4 = 1; id4 = w4; oe4 = 1;
        tick;
        iv4 = 0;
        eidx = 0;
        chk("tog_v0", ov4, 1);
        chk("tog_b0", od4, w4 & 32'hFF);
        for (int k = 0; k < 8; k++) begin
            oe4 = (k % 2 == 0);
            tick;
            if (oe4) eidx++;
            if (eidx < 4) begin
                chk("tog_v", ov4, 1);
                chk("tog_b", od4, (w4 >> (8 * eidx)) & 32'hFF);
            end else begin
                chk("tog_end", ov4, 0);
            end
        end
        oe4 = 0;

        // ---- blockSize=1 stream ----
        words1[0] = 8'h01; words1[1] = 8'h02; words1[2] = 8'h03;
        wi = 0; oe1 = 1;
        for (int c = 0; c < 10; c++) begin
            iv1 = (wi < 3);
            id1 = (wi < 3) ? words1[wi] : 8'h0;
            rdy = ir1;
            tick;
            if (iv1 && rdy) wi++;
            if (ov1) got1.push_back(od1);
            chk("bs1_idx", 32'(u1.idx), 0);
        end
        iv1 = 0;
        chk("bs1_count", got1.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < got1.size()) chk("bs1_byte", got1[i], words1[i]);

        // ---- reset mid-word ----
        iv2 = 1; id2 = 16'hA55A; oe2 = 0;
        tick;
        iv2 = 0;
        chk("mid_v0", ov2, 1);
        chk("mid_b0", od2, 8'h5A);
        reset = 1; oe2 = 1;
        tick;
        chk("mid_rst_v", ov2, 0);
        chk("mid_rst_d", od2, 0);
        chk("mid_rst_rdy", ir2, 0);
        reset = 0;
        tick;
        chk("mid_post_rdy", ir2, 1);
        chk("mid_post_v", ov2, 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("mid_noA5", (ov2 && od2 == 8'hA5), 0);
        end
        oe2 = 0;

        // ---- randomized run on blockSize=4 vs byte-queue model ----
        for (int c = 0; c < 400; c++) begin
            if (c < 360) begin
                iv4 = ($urandom_range(0, 2) != 0);
                id4 = $urandom;
                oe4 = $urandom_range(0, 1);
            end else begin
                iv4 = 0;
                oe4 = 1;
            end
            acc = iv4 && ir4;
            con = ov4 && oe4;
            pv  = ov4;
            pd  = od4;
            if (con) begin
                chk("rnd_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    expb = q.pop_front();
                    chk("rnd_byte", pd, expb);
                end
            end
            tick;
            if (acc)
                for (int i = 0; i < 4; i++) q.push_back(8'((id4 >> (8 * i)) & 32'hFF));
            if (pv && !con) begin
                chk("rnd_stall_v", ov4, 1);
                chk("rnd_stall_d", od4, pd);
            end
        end
        chk("rnd_drained", q.size(), 0);
        chk("rnd_end_v", ov4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/byte_mux.md
BYTE_MUX -- requirements
Module: byte_mux

Interface
REQ-001 SHALL have parameter: blockSize, default 2, number of bytes per input word (legal range 1..16).
REQ-002 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: inValid  input  1  upstream word present on inData.
REQ-005 SHALL have port: inReady  output  1  block can accept a word this cycle.
REQ-006 SHALL have port: inData  input  8*blockSize  word; byte 0 = bits [7:0].
REQ-007 SHALL have port: outEnable  input  1  downstream consumes current byte this cycle.
REQ-008 SHALL have port: outValid  output  1  outData holds a valid byte.
REQ-009 SHALL have port: outData  output  8  current byte, registered.

Function
REQ-010 SHALL transfer a word on every rising edge where inValid and inReady are both high; inData is ignored otherwise.
REQ-011 SHALL emit bytes little-endian: byte 0 (inData[7:0]) first, byte blockSize-1 last.
REQ-012 SHALL use states IDLE (no word held) and SHIFT (word held, byte index 0..blockSize-1).
REQ-013 SHALL take IDLE->SHIFT on word transfer; outValid=1 and outData=byte 0 in the cycle after the transfer edge (latency 1).
REQ-014 SHALL consume a byte only when outValid and outEnable are both high; outEnable while outValid=0 SHALL be ignored.
REQ-015 SHALL hold outData and outValid stable while outValid=1 and outEnable=0.
REQ-016 SHALL on consume of a non-last byte advance the index by 1 and present the next byte the following cycle.
REQ-017 SHALL on consume of the last byte either load a pending word (REQ-025) or return to IDLE with outValid=0, outData=0.
REQ-018 SHALL size the byte index max(1, $clog2(blockSize)) bits; the index SHALL never exceed blockSize-1 and SHALL wrap to 0 only on word completion.
REQ-019 SHALL with blockSize=1 emit each word as a single byte and return to IDLE after its consume.
REQ-020 SHALL drive inReady combinationally from registered state only (no path from inValid or outEnable).

Reset
REQ-021 SHALL while reset=1 force state IDLE, index 0, outValid=0, outData=0, inReady=0, and discard any held or pending word.
REQ-022 SHALL on reset mid-word drop remaining bytes; first cycle after reset deasserts: inReady=1, outValid=0.

Configuration
REQ-023 SHALL compile a second word-holding register in only when macro BYTE_MUX_DOUBLE_BUFFER_EN is defined.
REQ-024 SHALL without BYTE_MUX_DOUBLE_BUFFER_EN drive inReady = (state==IDLE); consecutive words then incur one idle cycle (outValid=0) between last byte of word N and byte 0 of word N+1.
REQ-025 SHALL with BYTE_MUX_DOUBLE_BUFFER_EN drive inReady = !pendingFull; a word accepted in SHIFT is stored pending and loaded on consume of the last byte, so byte 0 follows without a bubble.
REQ-026 SHALL with the macro load an IDLE-time transfer directly into the active register, and handle transfer and last-byte consume on the same edge by loading the accepted word as active.

Structure
REQ-027 SHALL place the state enum (IDLE, SHIFT) and constant BYTE_WIDTH=8 in shared package fm_stream_pkg.
REQ-028 SHALL implement the optional pending register as sub-module byte_mux_hold_reg (load, clear, full flag, data).

Verification
REQ-029 SHALL test: blockSize=2, word 0xBEEF, outEnable held 1 -> outData 0xEF then 0xBE on consecutive cycles, then outValid=0.
REQ-030 SHALL test: blockSize=4, word 0x12345678, outEnable toggling 1,0,1,0.. -> bytes 0x78,0x56,0x34,0x12, each held stable across stall cycles.
REQ-031 SHALL test: back-to-back words 0x1111, 0x2222, outEnable=1 -> without macro one outValid=0 cycle between 0x11 and 0x22; with macro none.
REQ-032 SHALL test: reset asserted after first byte of 0xA55A -> outValid=0, outData=0 next cycle, 0xA5 never emitted.
REQ-033 SHALL test: blockSize=1, words 0x01,0x02,0x03 -> outData 0x01,0x02,0x03 in order, index stays 0.
REQ-034 SHALL test: outEnable=1 while IDLE and inValid=0 for 10 cycles -> outValid remains 0, inReady remains 1.
